// File: rtl/demux_1x8.sv
// Registered 1-to-8 demultiplexer: routes d to y[{s2,s1,s0}], all other outputs idle.
// Define DEMUX_1X8_HOLD_EN to add input en; with en low the outputs hold their previous values.
module demux_1x8 #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
`ifdef DEMUX_1X8_HOLD_EN
    input  logic en,
`endif
    input  logic d,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7
);

    logic [2:0] sel;
    logic [7:0] y_nxt;
    logic [7:0] y_p1;
    logic       load;

    assign sel = {s2, s1, s0};

`ifdef DEMUX_1X8_HOLD_EN
    assign load = en;
`else
    assign load = 1'b1;
`endif

    // Stage p0 -> p1: decode. An unknown select falls through to default, so no output goes X.
    always_comb begin
        y_nxt = {8{IDLE_VAL}};
        case (sel)
            3'd0:    y_nxt[0] = d;
            3'd1:    y_nxt[1] = d;
            3'd2:    y_nxt[2] = d;
            3'd3:    y_nxt[3] = d;
            3'd4:    y_nxt[4] = d;
            3'd5:    y_nxt[5] = d;
            3'd6:    y_nxt[6] = d;
            3'd7:    y_nxt[7] = d;
            default: y_nxt = {8{IDLE_VAL}};
        endcase
    end

    // Reset clears to 0 regardless of IDLE_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_p1 <= 8'h00;
        end else if (load) begin
            y_p1 <= y_nxt;
        end
    end

    assign y0 = y_p1[0];
    assign y1 = y_p1[1];
    assign y2 = y_p1[2];
    assign y3 = y_p1[3];
    assign y4 = y_p1[4];
    assign y5 = y_p1[5];
    assign y6 = y_p1[6];
    assign y7 = y_p1[7];

endmodule

// File: tb/tb_demux_1x8.sv
// Directed scoreboard bench for demux_1x8 (default IDLE_VAL); hold checks when DEMUX_1X8_HOLD_EN is defined.
module tb_demux_1x8;

    logic clk;
    logic rst;
    logic d;
    logic s0, s1, s2;
`ifdef DEMUX_1X8_HOLD_EN
    logic en;
`endif
    logic y0, y1, y2, y3, y4, y5, y6, y7;

    logic [7:0] exp_q[$];
    int vectors;
    int miscompares;

    demux_1x8 dut (
        .clk(clk),
        .rst(rst),
`ifdef DEMUX_1X8_HOLD_EN
        .en (en),
`endif
        .d  (d),
        .s0 (s0),
        .s1 (s1),
        .s2 (s2),
        .y0 (y0),
        .y1 (y1),
        .y2 (y2),
        .y3 (y3),
        .y4 (y4),
        .y5 (y5),
        .y6 (y6),
        .y7 (y7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] onehot(input logic dv, input logic [2:0] sv);
        logic [7:0] v;
        v = 8'h00;
        v[sv] = dv;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {y7, y6, y5, y4, y3, y2, y1, y0};
    endfunction

    task automatic set_in(input logic dv, input logic [2:0] sv);
        d = dv;
        {s2, s1, s0} = sv;
    endtask

    task automatic compare_now(input string tag);
        logic [7:0] exp;
        logic [7:0] obs;
        vectors++;
        obs = outs();
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: observed %b, scoreboard empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b", tag, obs, exp);
            end
        end
    endtask

    // Wait for the next rising edge and compare 1 time unit later.
    task automatic compare_edge(input string tag);
        @(posedge clk);
        #1;
        compare_now(tag);
    endtask

    // Drive on the falling edge, predict, then check after the following rising edge.
    task automatic step(input logic dv, input logic [2:0] sv, input string tag);
        @(negedge clk);
        set_in(dv, sv);
        exp_q.push_back(onehot(dv, sv));
        compare_edge(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
`ifdef DEMUX_1X8_HOLD_EN
        en = 1'b1;
`endif
        rst = 1'b1;
        set_in(1'b1, 3'd5);
        #1;
        exp_q.push_back(8'h00);
        compare_now("reset_immediate");
        exp_q.push_back(8'h00);
        compare_edge("reset_hold_edge1");
        exp_q.push_back(8'h00);
        compare_edge("reset_hold_edge2");

        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(onehot(1'b1, 3'd5));
        compare_edge("reset_release_sel5");

        for (int i = 0; i < 8; i++) begin
            step(1'b1, i[2:0], $sformatf("sweep_sel%0d", i));
        end

        step(1'b0, 3'd6, "data_zero_sel6");

        // Select change between edges must not reach the outputs before the next edge.
        step(1'b1, 3'd2, "latency_sel2");
        set_in(1'b1, 3'd7);
        #2;
        exp_q.push_back(onehot(1'b1, 3'd2));
        compare_now("latency_hold_sel2");
        exp_q.push_back(onehot(1'b1, 3'd7));
        compare_edge("latency_sel7");

        step(1'b0, 3'd3, "simul_d_sel_change");
        step(1'b1, 3'd7, "wrap_sel7");
        step(1'b1, 3'd0, "wrap_sel0");

        // Asynchronous reset between edges.
        step(1'b1, 3'd4, "mid_run_sel4");
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(8'h00);
        compare_now("async_reset_mid_run");
        exp_q.push_back(8'h00);
        compare_edge("async_reset_held");
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(onehot(1'b1, 3'd4));
        compare_edge("async_reset_release");

`ifdef DEMUX_1X8_HOLD_EN
        step(1'b1, 3'd1, "hold_setup_sel1");
        @(negedge clk);
        en = 1'b0;
        set_in(1'b1, 3'd6);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(onehot(1'b1, 3'd1));
            compare_edge($sformatf("hold_en0_edge%0d", k));
            @(negedge clk);
        end
        en = 1'b1;
        exp_q.push_back(onehot(1'b1, 3'd6));
        compare_edge("hold_en1_sel6");
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        #1;
        exp_q.push_back(8'h00);
        compare_now("hold_rst_overrides_en");
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
`endif

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: observed %0d left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_1x8.md
DEMUX_1X8 -- requirements
Module: demux_1x8

Interface
REQ-001 SHALL provide parameter IDLE_VAL, default 1'b0, the value driven on every non-selected output.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL provide port d, input, 1 bit: data bit to be routed.
REQ-005 SHALL provide port s0, input, 1 bit: select bit 0 (LSB).
REQ-006 SHALL provide port s1, input, 1 bit: select bit 1.
REQ-007 SHALL provide port s2, input, 1 bit: select bit 2 (MSB).
REQ-008 SHALL provide ports y0..y7, outputs, 1 bit each, registered: demultiplexed outputs.

Function
REQ-009 SHALL form select index sel = {s2,s1,s0}, giving a range of 0..7.
REQ-010 SHALL, at each rising clk edge with rst low, load y[sel] <= d and every other y[k] <= IDLE_VAL.
REQ-011 SHALL have a latency of exactly one clock from d/s change to output change; there is no combinational path from inputs to outputs.
REQ-012 SHALL, with IDLE_VAL=0 and d=1, have exactly one output high; with d=0, all outputs are 0.
REQ-013 SHALL ensure that a select change between edges has no effect until the next edge, and that only values present at the edge matter.
REQ-014 SHALL make a simultaneous change of d and sel at the same edge take effect together on the following edge, with no intermediate state visible.
REQ-015 SHALL treat sel wrap from 7 to 0 as an ordinary index change, with no special handling.
REQ-016 SHALL resolve an unknown (X) select bit during simulation to all outputs = IDLE_VAL via a default branch; the design does not propagate X to a non-selected output.

Reset
REQ-017 SHALL, on rst high, drive y0..y7 immediately to 0, asynchronously and independent of clk and of IDLE_VAL.
REQ-018 SHALL hold outputs at 0 while rst is high.
REQ-019 SHALL resume normal loading (REQ-010) at the first rising clk edge after rst deasserts.
REQ-020 SHALL, when reset is asserted mid-operation, clear outputs within the same timestep with no wait for a clock.

Configuration
REQ-021 SHALL use macro DEMUX_1X8_HOLD_EN to compile in input port en (1 bit, active-high).
REQ-022 SHALL, with DEMUX_1X8_HOLD_EN defined and en=0 at a rising edge, hold all outputs at their previous values; with en=1, behave per REQ-010; rst overrides en.
REQ-023 SHALL, with DEMUX_1X8_HOLD_EN undefined, omit port en and update outputs at every rising edge.

Verification
REQ-024 SHALL verify reset: rst=1 with d=1 and sel=5 -> y0..y7 all 0 immediately and through clock edges; rst=0 -> next edge y5=1.
REQ-025 SHALL verify the select sweep: d=1, sel stepped 0..7 one per clock -> one edge later, only y[sel]=1 each cycle (e.g. sel=3 -> y3=1, others 0).
REQ-026 SHALL verify data zero: d=0 with any sel (e.g. 6) -> all outputs 0 after one edge.
REQ-027 SHALL verify latency: at sel=2 and d=1, change sel to 7 between edges -> y2 stays 1 until the next edge, then y7=1 and y2=0.
REQ-028 SHALL verify async reset mid-run: sel=4, d=1, y4=1, assert rst between edges -> y4=0 without a clock edge.
REQ-029 SHALL verify hold (DEMUX_1X8_HOLD_EN defined): y1=1, then en=0 with sel=6 for 3 edges -> y1 stays 1 and y6 stays 0; en=1 -> next edge y6=1.
